// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;

  localparam int       PC_W      = 12;
  localparam int       INSTR_W   = 16;
  localparam logic [1:0] OP_BRANCH = 2'd2;

  typedef logic [PC_W-1:0] pc_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    pc_t                pc;
  } fetch_entry_t;

  // Branch-class instructions are the ones the branch logic later resolves into br_*.
  function automatic logic is_branch(input logic [INSTR_W-1:0] instr);
    return instr[1:0] == OP_BRANCH;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through synchronous FIFO used to buffer fetched instructions.
// Flush clears every entry and takes priority over a same-cycle push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  input  logic                       flush,
  output entry_t                     head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push & ~flush;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; validity is tracked by count, so the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (rst) pop |-> !empty);
  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) (push && !pop && !flush) |-> !full);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: PC, credit-gated memory requests, response FIFO, branch redirect.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int  DEPTH    = 4,
  parameter pc_t RESET_PC = 12'h000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output pc_t                imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output pc_t                instr_pc,
  input  logic               br_valid,
  input  logic               br_taken,
  input  pc_t                br_target
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        perf_fetched,
  output logic [15:0]        perf_flushed,
  output logic [15:0]        perf_redirects
`endif
);

  localparam int               PTR_W = $clog2(DEPTH);
  localparam int               CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]   CAP   = (CNT_W + 1)'(DEPTH);

  pc_t              pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] stale;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  fetch_entry_t     fifo_head;
  fetch_entry_t     push_entry;

  pc_t              tag_mem [DEPTH];
  logic [PTR_W-1:0] tag_rd;
  logic [PTR_W-1:0] tag_wr;

  logic redirect;
  logic credit_ok;
  logic req_fire;
  logic rsp_push;
  logic rsp_drop;
  logic pop;

  assign redirect  = br_valid & br_taken;
  // In-flight requests plus buffered words never exceed DEPTH, so every response has a FIFO slot.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < CAP;

  assign imem_req_valid = ~rst & ~redirect & credit_ok;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign rsp_push = imem_rsp_valid & ~redirect & (stale == '0);
  assign rsp_drop = imem_rsp_valid & (redirect | (stale != '0));
  assign pop      = instr_valid & instr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= br_target;
    end else if (req_fire) begin
      pc <= pc + pc_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      stale       <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
      // Everything still in flight after this cycle belongs to the abandoned path.
      if (redirect) begin
        stale <= outstanding - CNT_W'(imem_rsp_valid);
      end else if (imem_rsp_valid && (stale != '0)) begin
        stale <= stale - CNT_W'(1);
      end
    end
  end

  // PC tags follow requests in order; stale responses never consume a tag since the queue was cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_rd <= '0;
      tag_wr <= '0;
    end else if (redirect) begin
      tag_rd <= '0;
      tag_wr <= '0;
    end else begin
      if (req_fire) tag_wr <= tag_wr + PTR_W'(1);
      if (rsp_push) tag_rd <= tag_rd + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[tag_wr] <= pc;
  end

  assign push_entry.instr = imem_rsp_data;
  assign push_entry.pc    = tag_mem[tag_rd];

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign instr_valid = ~fifo_empty;
  assign instr_data  = fifo_empty ? '0 : fifo_head.instr;
  assign instr_pc    = fifo_empty ? '0 : fifo_head.pc;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] flush_inc;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    flush_inc = '0;
    if (redirect) flush_inc = 16'(fifo_count) - 16'(pop);
    if (rsp_drop) flush_inc = flush_inc + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched   <= '0;
      perf_flushed   <= '0;
      perf_redirects <= '0;
    end else begin
      perf_fetched   <= sat_add16(perf_fetched, 16'(rsp_push));
      perf_flushed   <= sat_add16(perf_flushed, flush_inc);
      perf_redirects <= sat_add16(perf_redirects, 16'(redirect));
    end
  end
`endif

  a_rsp_has_request: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (outstanding != '0));
  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, outstanding} + {1'b0, fifo_count}) <= CAP);
  a_push_has_room: assert property (@(posedge clk) disable iff (rst)
    (rsp_push && !pop) |-> !fifo_full);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model of memory, in-flight requests and FIFO.
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [11:0] RESET_PC = 12'h000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [11:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_data;
  logic [11:0] instr_pc;
  logic        br_valid;
  logic        br_taken;
  logic [11:0] br_target;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_flushed;
  logic [15:0] perf_redirects;
`endif

  fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .br_valid       (br_valid),
    .br_taken       (br_taken),
    .br_target      (br_target)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed),
    .perf_redirects (perf_redirects)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    bit          stale;
    int          due;
  } req_t;

  typedef struct {
    logic [15:0] data;
    logic [11:0] pc;
  } ent_t;

  req_t        inflight[$];
  ent_t        fifo_q[$];
  logic [11:0] model_pc;
  int          cyc;
  int          last_due;
  int          lat;
  int          m_fetched;
  int          m_flushed;
  int          m_redirects;

  int checks   = 0;
  int failures = 0;

  logic        exp_req_valid, obs_req_valid;
  logic [11:0] exp_addr, obs_addr;
  logic        exp_instr_valid, obs_instr_valid;
  logic [15:0] exp_data, obs_data;
  logic [11:0] exp_pc, obs_pc;
  bit          obs_fire;

  function automatic logic [15:0] mem_word(input logic [11:0] addr);
    return {addr[3:0], addr} ^ 16'hA5C3;
  endfunction

  task automatic model_reset();
    inflight.delete();
    fifo_q.delete();
    model_pc    = RESET_PC;
    cyc         = 0;
    last_due    = -1;
    m_fetched   = 0;
    m_flushed   = 0;
    m_redirects = 0;
  endtask

  task automatic drive_idle();
    br_valid       = 1'b0;
    br_taken       = 1'b0;
    br_target      = 12'h000;
    instr_ready    = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 16'h0000;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: entered and left 1 time unit after a rising edge.
  task automatic step(input bit bv, input bit bt, input logic [11:0] tgt, input bit irdy, input bit qrdy);
    bit   redirect, arrive, fire, pop_now;
    req_t r;
    ent_t e;
    int   due;
    redirect = bv && bt;
    arrive   = (inflight.size() > 0) && (inflight[0].due <= cyc);
    br_valid       = bv;
    br_taken       = bt;
    br_target      = tgt;
    instr_ready    = irdy;
    imem_req_ready = qrdy;
    imem_rsp_valid = arrive;
    imem_rsp_data  = arrive ? mem_word(inflight[0].addr) : 16'h0000;

    exp_req_valid   = !redirect && ((inflight.size() + fifo_q.size()) < DEPTH);
    exp_addr        = model_pc;
    exp_instr_valid = fifo_q.size() > 0;
    exp_data        = exp_instr_valid ? fifo_q[0].data : 16'h0000;
    exp_pc          = exp_instr_valid ? fifo_q[0].pc : 12'h000;

    #2;
    obs_req_valid   = imem_req_valid;
    obs_addr        = imem_req_addr;
    obs_instr_valid = instr_valid;
    obs_data        = instr_data;
    obs_pc          = instr_pc;
    obs_fire        = (imem_req_valid === 1'b1) && qrdy;

    fire    = exp_req_valid && qrdy;
    pop_now = exp_instr_valid && irdy;
    if (pop_now) void'(fifo_q.pop_front());
    if (arrive) begin
      r = inflight.pop_front();
      if (redirect || r.stale) begin
        m_flushed++;
      end else begin
        e.data = mem_word(r.addr);
        e.pc   = r.addr;
        fifo_q.push_back(e);
        m_fetched++;
      end
    end
    if (redirect) begin
      m_flushed += fifo_q.size();
      fifo_q.delete();
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      model_pc = tgt;
      m_redirects++;
    end
    if (fire) begin
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = due;
      r.addr  = model_pc;
      r.stale = 1'b0;
      r.due   = due;
      inflight.push_back(r);
      model_pc = model_pc + 12'd1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    #2;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL reset_req_valid got=%b want=0", imem_req_valid);
    end
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++; $display("FAIL reset_instr_valid got=%b want=0", instr_valid);
    end
    checks++;
    if (instr_data !== 16'h0000 || instr_pc !== 12'h000) begin
      failures++; $display("FAIL reset_instr_out got data=%h pc=%h want 0000/000", instr_data, instr_pc);
    end
    checks++;
    if (imem_req_addr !== RESET_PC) begin
      failures++; $display("FAIL reset_pc got=%h want=%h", imem_req_addr, RESET_PC);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_stream();
    int first_fire, first_valid;
    first_fire  = -1;
    first_valid = -1;
    lat = 1;
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
      if (obs_fire && first_fire < 0) first_fire = i;
      if (obs_instr_valid === 1'b1 && first_valid < 0) first_valid = i;
      checks++;
      if (obs_req_valid !== exp_req_valid || (exp_req_valid && obs_addr !== exp_addr)) begin
        failures++; $display("FAIL stream_req cyc=%0d got v=%b a=%h want v=%b a=%h", cyc, obs_req_valid, obs_addr, exp_req_valid, exp_addr);
      end
      checks++;
      if (obs_instr_valid !== exp_instr_valid || (exp_instr_valid && (obs_data !== exp_data || obs_pc !== exp_pc))) begin
        failures++; $display("FAIL stream_instr cyc=%0d got v=%b d=%h pc=%h want v=%b d=%h pc=%h", cyc, obs_instr_valid, obs_data, obs_pc, exp_instr_valid, exp_data, exp_pc);
      end
    end
    checks++;
    if (first_fire != 0 || first_valid != 2) begin
      failures++; $display("FAIL stream_first_latency got fire=%0d valid=%0d want fire=0 valid=2", first_fire, first_valid);
    end
  endtask

  task automatic test_backpressure();
    int fires;
    lat = 1;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
    fires = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
      if (obs_fire) fires++;
      checks++;
      if (obs_req_valid !== exp_req_valid || (exp_req_valid && obs_addr !== exp_addr)) begin
        failures++; $display("FAIL bp_req cyc=%0d got v=%b a=%h want v=%b a=%h", cyc, obs_req_valid, obs_addr, exp_req_valid, exp_addr);
      end
    end
    checks++;
    if (fires != 4 || obs_req_valid !== 1'b0) begin
      failures++; $display("FAIL bp_fire_count got fires=%0d valid=%b want fires=4 valid=0", fires, obs_req_valid);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
      checks++;
      if (obs_req_valid !== exp_req_valid || (exp_req_valid && obs_addr !== exp_addr)) begin
        failures++; $display("FAIL bp_resume_req cyc=%0d got v=%b a=%h want v=%b a=%h", cyc, obs_req_valid, obs_addr, exp_req_valid, exp_addr);
      end
      checks++;
      if (obs_instr_valid !== exp_instr_valid || (exp_instr_valid && (obs_data !== exp_data || obs_pc !== exp_pc))) begin
        failures++; $display("FAIL bp_resume_instr cyc=%0d got v=%b d=%h pc=%h want v=%b d=%h pc=%h", cyc, obs_instr_valid, obs_data, obs_pc, exp_instr_valid, exp_data, exp_pc);
      end
    end
  endtask

  task automatic test_redirect_stale();
    bit          seen;
    logic [11:0] got_pc;
    lat = 3;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
    step(1'b1, 1'b1, 12'h200, 1'b1, 1'b0);
    checks++;
    if (obs_req_valid !== 1'b0) begin
      failures++; $display("FAIL stale_req_on_redirect got=%b want=0", obs_req_valid);
    end
    seen = 1'b0;
    got_pc = 12'h000;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
      if (obs_instr_valid === 1'b1) begin
        seen = 1'b1;
        got_pc = obs_pc;
      end
      checks++;
      if (obs_instr_valid !== exp_instr_valid || (exp_instr_valid && (obs_data !== exp_data || obs_pc !== exp_pc))) begin
        failures++; $display("FAIL stale_instr cyc=%0d got v=%b d=%h pc=%h want v=%b d=%h pc=%h", cyc, obs_instr_valid, obs_data, obs_pc, exp_instr_valid, exp_data, exp_pc);
      end
    end
    checks++;
    if (!seen || got_pc !== 12'h200) begin
      failures++; $display("FAIL stale_first_pc got seen=%b pc=%h want pc=200", seen, got_pc);
    end
  endtask

  task automatic test_redirect_pop();
    bit          seen;
    logic [11:0] tgt, got_pc;
    lat = 1;
    tgt = 12'($urandom_range(12'h100, 12'hEFF));
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
    step(1'b1, 1'b1, tgt, 1'b1, 1'b1);
    checks++;
    if (obs_instr_valid !== exp_instr_valid || (exp_instr_valid && (obs_data !== exp_data || obs_pc !== exp_pc))) begin
      failures++; $display("FAIL popredir_head got v=%b d=%h pc=%h want v=%b d=%h pc=%h", obs_instr_valid, obs_data, obs_pc, exp_instr_valid, exp_data, exp_pc);
    end
    seen = 1'b0;
    got_pc = 12'h000;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
      if (obs_instr_valid === 1'b1) begin
        seen = 1'b1;
        got_pc = obs_pc;
      end
    end
    checks++;
    if (!seen || got_pc !== tgt) begin
      failures++; $display("FAIL popredir_first_pc got seen=%b pc=%h want pc=%h", seen, got_pc, tgt);
    end
  endtask

  task automatic test_wrap_and_reset();
    logic [11:0] addrs[$];
    logic [11:0] a0, a1, a2;
    lat = 1;
    step(1'b1, 1'b1, 12'hFFE, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
      if (obs_fire) addrs.push_back(obs_addr);
      checks++;
      if (obs_instr_valid !== exp_instr_valid || (exp_instr_valid && (obs_data !== exp_data || obs_pc !== exp_pc))) begin
        failures++; $display("FAIL wrap_instr cyc=%0d got v=%b d=%h pc=%h want v=%b d=%h pc=%h", cyc, obs_instr_valid, obs_data, obs_pc, exp_instr_valid, exp_data, exp_pc);
      end
    end
    a0 = (addrs.size() > 0) ? addrs[0] : 12'hXXX;
    a1 = (addrs.size() > 1) ? addrs[1] : 12'hXXX;
    a2 = (addrs.size() > 2) ? addrs[2] : 12'hXXX;
    checks++;
    if (a0 !== 12'hFFE || a1 !== 12'hFFF || a2 !== 12'h000) begin
      failures++; $display("FAIL wrap_addrs got %h %h %h want ffe fff 000", a0, a1, a2);
    end
    rst = 1'b1;
    imem_rsp_valid = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || imem_req_addr !== RESET_PC) begin
      failures++; $display("FAIL midreset got req_v=%b instr_v=%b addr=%h want 0 0 %h", imem_req_valid, instr_valid, imem_req_addr, RESET_PC);
    end
    drive_idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    bit bv, bt, irdy, qrdy;
    for (int i = 0; i < 400; i++) begin
      if (i % 64 == 0) lat = $urandom_range(1, 3);
      bv   = ($urandom_range(0, 7) == 0);
      bt   = $urandom_range(0, 1) == 1;
      irdy = ($urandom_range(0, 3) != 0);
      qrdy = ($urandom_range(0, 3) != 0);
      step(bv, bt, 12'($urandom), irdy, qrdy);
      checks++;
      if (obs_req_valid !== exp_req_valid || (exp_req_valid && obs_addr !== exp_addr)) begin
        failures++; $display("FAIL rand_req cyc=%0d got v=%b a=%h want v=%b a=%h", cyc, obs_req_valid, obs_addr, exp_req_valid, exp_addr);
      end
      checks++;
      if (obs_instr_valid !== exp_instr_valid || (exp_instr_valid && (obs_data !== exp_data || obs_pc !== exp_pc))) begin
        failures++; $display("FAIL rand_instr cyc=%0d got v=%b d=%h pc=%h want v=%b d=%h pc=%h", cyc, obs_instr_valid, obs_data, obs_pc, exp_instr_valid, exp_data, exp_pc);
      end
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    apply_reset();
    lat = 1;
    step(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
    step(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
    step(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    step(1'b1, 1'b1, 12'h040, 1'b0, 1'b0);
    step(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
    step(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    step(1'b1, 1'b1, 12'h080, 1'b0, 1'b0);
    step(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    checks++;
    if (perf_redirects !== 16'd2 || m_redirects != 2) begin
      failures++; $display("FAIL perf_redirects got=%0d want=2", perf_redirects);
    end
    checks++;
    if (perf_flushed !== 16'd3 || m_flushed != 3) begin
      failures++; $display("FAIL perf_flushed got=%0d want=3", perf_flushed);
    end
    checks++;
    if (perf_fetched !== 16'd3 || m_fetched != 3) begin
      failures++; $display("FAIL perf_fetched got=%0d want=3", perf_fetched);
    end
  endtask
`endif

  initial begin
    lat = 1;
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_stale();
    test_redirect_pop();
    test_wrap_and_reset();
    test_random();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
